// File: rtl/reset_sequencer.sv
// Power-on / PLL-lock reset sequencer: qualifies lock, waits a settle time, then releases N_CH domains staggered.
// Optional saturating lock-loss counter on port lock_loss_cnt when RST_SEQ_LOSS_CNT_EN is defined.
module reset_sequencer #(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LOCK_FILT   = 8,
  parameter int unsigned WAIT_CYCLES = 5000000,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SW_HOLD     = 5
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic            locked,
  input  logic            sw_reset,
  output logic [N_CH-1:0] reset,
  output logic [N_CH-1:0] en,
  output logic            ready
`ifdef RST_SEQ_LOSS_CNT_EN
  , output logic [7:0]    lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILT,
    ST_WAIT,
    ST_REL,
    ST_RUN,
    ST_HOLD
  } state_t;

  localparam longint unsigned CNT_MAX =
    (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);
  localparam longint unsigned REL_SPAN = 64'(STAGE_GAP) * 64'(N_CH - 1);

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_SPAN);

  if (N_CH < 1 || N_CH > 8) begin : g_chk_nch
    $error("reset_sequencer: N_CH must be in 1..8");
  end
  if (CNT_W < 1) begin : g_chk_cntw
    $error("reset_sequencer: CNT_W must be at least 1");
  end
  if (LOCK_FILT < 1 || 64'(LOCK_FILT) > CNT_MAX) begin : g_chk_filt
    $error("reset_sequencer: LOCK_FILT must be >= 1 and fit in CNT_W bits");
  end
  if (64'(WAIT_CYCLES) > CNT_MAX) begin : g_chk_wait
    $error("reset_sequencer: WAIT_CYCLES does not fit in CNT_W bits");
  end
  if (REL_SPAN > CNT_MAX) begin : g_chk_gap
    $error("reset_sequencer: STAGE_GAP*(N_CH-1) does not fit in CNT_W bits");
  end
  if (SW_HOLD < 1 || 64'(SW_HOLD) > CNT_MAX) begin : g_chk_hold
    $error("reset_sequencer: SW_HOLD must be >= 1 and fit in CNT_W bits");
  end

  logic             lock_m;
  logic             locked_s;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [N_CH-1:0]  reset_d;
  logic             ready_d;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      lock_m   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      lock_m   <= locked;
      locked_s <= lock_m;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      reset <= '1;
      en    <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      reset <= reset_d;
      en    <= ~reset_d;
      ready <= ready_d;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // One counter is shared by every timed state; it restarts from zero on each
  // state entry, and the IDLE edge that first sees lock already counts as filter cycle 1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (state != ST_IDLE && !locked_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_IDLE, ST_FILT: begin
          if (locked_s) begin
            if (cnt_inc == FILT_LAST) begin
              cnt_d = '0;
              if (WAIT_LAST == '0)
                state_d = (REL_LAST == '0) ? ST_RUN : ST_REL;
              else
                state_d = ST_WAIT;
            end else begin
              state_d = ST_FILT;
              cnt_d   = cnt_inc;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_inc == WAIT_LAST) begin
            cnt_d   = '0;
            state_d = (REL_LAST == '0) ? ST_RUN : ST_REL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_REL: begin
          cnt_d = cnt_inc;
          if (cnt_inc == REL_LAST)
            state_d = ST_RUN;
        end
        ST_RUN: begin
          if (sw_reset) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_inc == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = (REL_LAST == '0) ? ST_RUN : ST_REL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are precomputed from the next state so they register on the transition edge;
  // ascending thresholds guarantee domains never release out of order.
  always_comb begin
    reset_d = '1;
    ready_d = 1'b0;
    if (state_d == ST_RUN) begin
      reset_d = '0;
      ready_d = 1'b1;
    end else if (state_d == ST_REL) begin
      for (int unsigned k = 0; k < N_CH; k++)
        reset_d[k] = (cnt_d < CNT_W'(k * STAGE_GAP));
    end
  end

`ifdef RST_SEQ_LOSS_CNT_EN
  logic lock_lost;

  assign lock_lost = (state != ST_IDLE) && !locked_s;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)
      lock_loss_cnt <= '0;
    else if (lock_lost && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timestamp-based reference model queues expected outputs per edge,
// a negedge monitor compares them; directed scenarios add explicit timing checks, then random lock/sw_reset traffic.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int LF = 8;
  localparam int WC = 20;
  localparam int G  = 4;
  localparam int SH = 5;
  localparam longint LAST = G * (N - 1);

  logic         sysclk;
  logic         reset_n;
  logic         locked;
  logic         sw_reset;
  logic [N-1:0] reset;
  logic [N-1:0] en;
  logic         ready;
  logic [7:0]   loss_dut;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .N_CH(N),
    .CNT_W(16),
    .LOCK_FILT(LF),
    .WAIT_CYCLES(WC),
    .STAGE_GAP(G),
    .SW_HOLD(SH)
  ) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .locked(locked),
    .sw_reset(sw_reset),
    .reset(reset),
    .en(en),
    .ready(ready)
`ifdef RST_SEQ_LOSS_CNT_EN
    , .lock_loss_cnt(loss_dut)
`endif
  );

`ifndef RST_SEQ_LOSS_CNT_EN
  assign loss_dut = 8'd0;
`endif

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [N-1:0] rst;
    logic         rdy;
    logic [7:0]   loss;
  } exp_t;

  exp_t expq[$];

  // Reference model: lock history as a 2-sample delay, release schedule as a timestamp.
  longint edge_n = 0;
  bit     s1, s2, prev_ls;
  int     good;
  bit     have_rel;
  longint rel_at;
  int     loss_m;

  always @(posedge sysclk) begin
    exp_t e;
    bit   ls;
    edge_n++;
    if (!reset_n) begin
      s1 = 0; s2 = 0; prev_ls = 0; good = 0; have_rel = 0; rel_at = 0; loss_m = 0;
    end else begin
      ls = s2;
      s2 = s1;
      s1 = locked;
      if (!ls) begin
        if (prev_ls && loss_m < 255) loss_m++;
        good = 0;
        have_rel = 0;
      end else if (sw_reset && have_rel && edge_n > rel_at + LAST) begin
        rel_at = edge_n + SH;
      end else if (good < LF) begin
        good++;
        if (good == LF) begin
          have_rel = 1;
          rel_at = edge_n + WC;
        end
      end
      prev_ls = ls;
    end
    for (int k = 0; k < N; k++)
      e.rst[k] = !(have_rel && edge_n >= rel_at + longint'(k * G));
    e.rdy  = have_rel && edge_n >= rel_at + LAST;
    e.loss = 8'(loss_m);
    expq.push_back(e);
  end

  always @(negedge sysclk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (reset !== e.rst) begin
        errors++;
        $display("FAIL mon_reset t=%0t actual=%b expected=%b", $time, reset, e.rst);
      end
      checks++;
      if (en !== ~e.rst) begin
        errors++;
        $display("FAIL mon_en t=%0t actual=%b expected=%b", $time, en, ~e.rst);
      end
      checks++;
      if (ready !== e.rdy) begin
        errors++;
        $display("FAIL mon_ready t=%0t actual=%b expected=%b", $time, ready, e.rdy);
      end
`ifdef RST_SEQ_LOSS_CNT_EN
      checks++;
      if (loss_dut !== e.loss) begin
        errors++;
        $display("FAIL mon_loss t=%0t actual=%0d expected=%0d", $time, loss_dut, e.loss);
      end
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] r, input logic rd);
    checks++;
    if (reset !== r) begin
      errors++;
      $display("FAIL %s reset actual=%b expected=%b", name, reset, r);
    end
    checks++;
    if (en !== ~r) begin
      errors++;
      $display("FAIL %s en actual=%b expected=%b", name, en, ~r);
    end
    checks++;
    if (ready !== rd) begin
      errors++;
      $display("FAIL %s ready actual=%b expected=%b", name, ready, rd);
    end
  endtask

  // Assumes locked was just raised after an edge with the sequencer idle; checks edges 29..38.
  task automatic expect_start(input string name);
    step(29); expect_out({name, "_e29"}, 3'b111, 1'b0);
    step(1);  expect_out({name, "_e30"}, 3'b110, 1'b0);
    step(4);  expect_out({name, "_e34"}, 3'b100, 1'b0);
    step(4);  expect_out({name, "_e38"}, 3'b000, 1'b1);
  endtask

  task automatic relock();
    locked = 1'b0;
    step(4);
    expect_out("relock_idle", 3'b111, 1'b0);
    locked = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int drop_left;
    reset_n  = 1'b0;
    locked   = 1'b0;
    sw_reset = 1'b0;
    step(3);
    expect_out("reset_state", 3'b111, 1'b0);
    reset_n = 1'b1;
    step(2);
    expect_out("idle_no_lock", 3'b111, 1'b0);

    // Normal start
    locked = 1'b1;
    expect_start("normal");

    // Software reset in RUN
    step(2);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;
    expect_out("sw_hold", 3'b111, 1'b0);
    step(5); expect_out("sw_rel0", 3'b110, 1'b0);
    step(4); expect_out("sw_rel1", 3'b100, 1'b0);
    step(4); expect_out("sw_rel2", 3'b000, 1'b1);

    // Lock loss mid-release
    relock();
    step(35);
    expect_out("midrel_e35", 3'b100, 1'b0);
    locked = 1'b0;
    step(2);
    expect_out("midrel_sync", 3'b100, 1'b0);
    step(1);
    expect_out("midrel_lost", 3'b111, 1'b0);
    locked = 1'b1;
    expect_start("midrel_relock");

    // sw_reset on the same edge the FSM sees lock loss
    locked = 1'b0;
    step(2);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;
    expect_out("prio_idle", 3'b111, 1'b0);
    locked = 1'b1;
    step(5);
    expect_out("prio_nohold", 3'b111, 1'b0);
    step(25); expect_out("prio_e30", 3'b110, 1'b0);
    step(8);  expect_out("prio_e38", 3'b000, 1'b1);

    // sw_reset during WAIT is ignored
    relock();
    step(15);
    sw_reset = 1'b1;
    step(1);
    sw_reset = 1'b0;
    step(13); expect_out("wait_sw_e29", 3'b111, 1'b0);
    step(1);  expect_out("wait_sw_e30", 3'b110, 1'b0);
    step(8);  expect_out("wait_sw_e38", 3'b000, 1'b1);

    // Lock glitch in filter
    relock();
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(29); expect_out("glitch_e35", 3'b111, 1'b0);
    step(1);  expect_out("glitch_e36", 3'b110, 1'b0);
    step(8);  expect_out("glitch_e44", 3'b000, 1'b1);

    // Async reset mid-RUN
    @(negedge sysclk);
    #1;
    reset_n = 1'b0;
    #1;
    expect_out("async_rst", 3'b111, 1'b0);
`ifdef RST_SEQ_LOSS_CNT_EN
    checks++;
    if (loss_dut !== 8'd0) begin
      errors++;
      $display("FAIL async_loss actual=%0d expected=0", loss_dut);
    end
`endif
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    expect_start("after_async");

    // Randomized lock glitches and sw_reset pulses
    drop_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (drop_left > 0) begin
        locked = 1'b0;
        drop_left--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 99) < 2) drop_left = $urandom_range(1, 4);
      end
      sw_reset = (!sw_reset && $urandom_range(0, 15) == 0);
      step(1);
    end
    sw_reset = 1'b0;
    step(3);
    checks++;
    if (expq.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected<=1", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on and PLL-lock reset sequencer. It holds downstream logic in reset until the PLL lock is stable and a settle time has elapsed, then releases N_CH reset domains in staggered order. It re-sequences on lock loss or on a software reset request. It sits directly after the clock-generation PLL and drives the per-domain reset/enable pairs of the clock/stopwatch datapath.

Parameters:
N_CH, 3, number of reset domains (1..8)
CNT_W, 32, width of the shared delay counter
LOCK_FILT, 8, consecutive synchronised lock-high cycles required before settling (>=1)
WAIT_CYCLES, 5000000, settle cycles after lock is qualified (0 = no settle)
STAGE_GAP, 4, cycles between release of domain k and domain k+1 (0 = all release together)
SW_HOLD, 5, cycles the domains stay in reset after a software reset request (>=1)

Ports:
sysclk  in  1  system clock
reset_n  in  1  asynchronous active-low reset (async assert, internal state cleared immediately)
locked  in  1  PLL lock, asynchronous to sysclk
sw_reset  in  1  synchronous software reset request, single-cycle pulse
reset  out  N_CH  per-domain reset, active-high
en  out  N_CH  per-domain enable, always equal to ~reset
ready  out  1  high when all domains are released (state RUN)
lock_loss_cnt  out  8  saturating lock-loss counter (present only with macro, see below)

Behaviour:
- reset_n low: state IDLE, all counters 0, synchroniser flops 0, reset = all ones, en = 0, ready = 0.
- locked passes through a 2-flop synchroniser; locked_s is the second flop. All decisions use locked_s.
- All outputs are registered. en[k] and reset[k] change on the same edge.
- Timing contract: edge 1 is the first edge that samples locked = 1. reset[k] falls on edge 2 + LOCK_FILT + WAIT_CYCLES + k*STAGE_GAP. ready rises on the same edge as reset[N_CH-1].
- FSM states:
  - IDLE: wait for locked_s = 1, then go to FILT.
  - FILT: count consecutive locked_s = 1 cycles. Any 0 clears the count and returns to IDLE. At LOCK_FILT go to WAIT, or to RELEASE if WAIT_CYCLES = 0.
  - WAIT: count WAIT_CYCLES, then go to RELEASE.
  - RELEASE: release domain 0, then one domain every STAGE_GAP cycles, in ascending index order.
  - RUN: all domains released, ready = 1. The counter holds; no wrap.
  - HOLD: all domains in reset for SW_HOLD cycles, then go to RELEASE. Lock filtering and WAIT are skipped.
- Lock loss (locked_s = 0) in FILT, WAIT, RELEASE, RUN or HOLD:
  - Next edge: state IDLE and reset = all ones, en = 0, ready = 0.
  - Partially released domains are re-asserted together.
- sw_reset:
  - Acted on only in RUN; next edge enters HOLD with reset = all ones.
  - Ignored in all other states.
- Simultaneous lock loss and sw_reset: lock loss wins (IDLE).
- N_CH = 1, or STAGE_GAP = 0: all domains release on the first RELEASE edge, and ready rises on that same edge.
- Counter compare uses CNT_W bits. Elaboration error if WAIT_CYCLES, STAGE_GAP*(N_CH-1) or SW_HOLD does not fit in CNT_W.
- Reset domains never release out of order. reset[k] = 0 implies reset[j] = 0 for all j < k.

Optional Feature:
RST_SEQ_LOSS_CNT_EN
- Defined:
  - lock_loss_cnt port exists.
  - Increments by 1 on each transition from FILT, WAIT, RELEASE, RUN or HOLD to IDLE caused by locked_s = 0.
  - Saturates at 255; cleared only by reset_n.
  - sw_reset does not affect it.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
Parameters for all scenarios: N_CH = 3, LOCK_FILT = 8, WAIT_CYCLES = 20, STAGE_GAP = 4, SW_HOLD = 5.
1. Normal start: reset_n high, locked rises and stays high -> reset[0] falls at edge 30, reset[1] at 34, reset[2] at 38, ready = 1 at 38, en == ~reset throughout.
2. Lock glitch in filter: locked high 5 cycles, low 1 cycle, then high -> no release before 30 edges after the final rise; reset stays 3'b111 meanwhile.
3. Lock loss mid-release: locked drops for 3 cycles between edges 34 and 38 -> reset = 3'b111 two sysclk edges plus one FSM edge after the drop; full sequence restarts on relock; with macro, lock_loss_cnt = 1.
4. Software reset: in RUN, pulse sw_reset one cycle -> reset = 3'b111 next edge, reset[0] falls 5 edges later, then 4 and 8 edges later for domains 1 and 2; ready returns; lock_loss_cnt unchanged.
5. Priority: sw_reset pulsed on the same cycle locked_s falls -> state IDLE (no HOLD); sw_reset pulsed during WAIT -> ignored, timing identical to scenario 1.
6. Async reset mid-RUN: reset_n low for a half cycle -> reset = 3'b111, ready = 0 immediately without a clock edge; with macro, lock_loss_cnt = 0; after reset_n high and locked high, scenario 1 timing repeats.
